// File: rtl/rr_ch_arbiter_pkg.sv
// Shared types and defaults for the round-robin channel arbiter.
// Imported by the interface, the picker and the arbiter top.
package rr_arb_pkg;

  localparam int NUM_CH_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int CH_W_DEF   = $clog2(NUM_CH_DEF);

  typedef enum logic {
    IDLE,
    BURST_HOLD
  } state_t;

  typedef logic [CH_W_DEF-1:0] ch_idx_t;

endpackage

// File: rtl/rr_ch_arbiter_if.sv
// Valid/ready bundle: N input channels merged onto one output.
// slave = arbiter side, master = producer/consumer side.
interface rr_ch_arbiter_if
  import rr_arb_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ch
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ch
  );

endinterface

// File: rtl/rr_ch_arbiter_pick.sv
// Rotating first-one finder: searches req upward from ptr,
// wrapping modulo NUM_CH (power of two).
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter  int NUM_CH = NUM_CH_DEF,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_ptr,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [CH_W-1:0]   o_idx,
  output logic              o_any
);

  // first requester at or after ptr, in rotating order
  always_comb begin
    logic [CH_W-1:0]   w_pos;
    logic [NUM_CH-1:0] w_gnt;
    logic [CH_W-1:0]   w_idx;
    logic              w_found;
    w_pos   = '0;
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pos = i_ptr + CH_W'(i);
      if (!w_found && i_req[w_pos]) begin
        w_found      = 1'b1;
        w_idx        = w_pos;
        w_gnt[w_pos] = 1'b1;
      end
    end
    o_gnt = w_gnt;
    o_idx = w_idx;
    o_any = w_found;
  end

endmodule

// File: rtl/rr_ch_arbiter.sv
// Round-robin N:1 channel arbiter with burst hold,
// enable mask and a one-entry registered output stage.
module rr_ch_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int NUM_CH = NUM_CH_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int BURST  = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic [15:0]       beat_cnt,
  rr_ch_arbiter_if.slave    bus
);

  localparam int BC_W = 5;

  state_t            r_state;
  logic [CH_W-1:0]   r_ptr;
  logic [CH_W-1:0]   r_owner;
  logic [BC_W-1:0]   r_bc;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CH_W-1:0]   r_out_ch;
  logic [15:0]       r_beat_cnt;

  logic              w_load_en;
  logic [NUM_CH-1:0] w_req;
  logic              w_hold;
  logic [CH_W-1:0]   w_pick_ptr;
  logic [NUM_CH-1:0] w_pick_gnt;
  logic [CH_W-1:0]   w_pick_idx;
  logic              w_pick_any;
  logic              w_fire;
  logic [CH_W-1:0]   w_gidx;
  logic [BC_W-1:0]   w_bc_nxt;
  logic [DATA_W-1:0] w_gdata;

  // on release the search starts just past the old owner
  rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .i_req (w_req),
    .i_ptr (w_pick_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // grant decision: keep the burst owner, else rotate
  always_comb begin
    w_load_en  = !r_out_valid || bus.out_ready;
    w_req      = bus.in_valid & ch_enable;
    w_hold     = (r_state == BURST_HOLD) && w_req[r_owner];
    w_pick_ptr = (r_state == BURST_HOLD)
               ? r_owner + CH_W'(1) : r_ptr;
    w_fire     = !reset && w_load_en
               && (w_hold || w_pick_any);
    w_gidx     = w_hold ? r_owner : w_pick_idx;
    w_bc_nxt   = w_hold ? r_bc + BC_W'(1) : BC_W'(1);
    w_gdata    = bus.in_data[w_gidx*DATA_W +: DATA_W];
    bus.in_ready = '0;
    if (w_fire) begin
      if (w_hold) bus.in_ready[r_owner] = 1'b1;
      else        bus.in_ready = w_pick_gnt;
    end
  end

  // output register, beat counter and burst FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_bc        <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_beat_cnt  <= '0;
    end else begin
      if (r_out_valid && bus.out_ready
          && r_beat_cnt != 16'hFFFF)
        r_beat_cnt <= r_beat_cnt + 16'd1;
      if (w_fire) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gdata;
        r_out_ch    <= w_gidx;
      end else if (w_load_en) begin
        r_out_valid <= 1'b0;
      end
      if (w_fire) begin
        r_bc <= w_bc_nxt;
        if (w_bc_nxt >= BC_W'(BURST)) begin
          r_state <= IDLE;
          r_ptr   <= w_gidx + CH_W'(1);
        end else begin
          r_state <= BURST_HOLD;
          r_owner <= w_gidx;
        end
      end else if (w_load_en && r_state == BURST_HOLD) begin
        r_state <= IDLE;
        r_ptr   <= r_owner + CH_W'(1);
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign beat_cnt      = r_beat_cnt;

endmodule

// File: tb/tb_rr_ch_arbiter.sv
// Directed bench for rr_ch_arbiter: BURST=4 and BURST=1
// instances, hand-computed grant orders per scenario.
module tb_rr_ch_arbiter;
  import rr_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  en4;
  logic [7:0]  en1;
  logic [15:0] cnt4;
  logic [15:0] cnt1;
  int          tests = 0;
  int          fails = 0;

  int mask_seq [7] = '{0, 1, 3, 4, 5, 6, 7};
  logic [7:0] rel_rdy [7] =
    '{8'h02, 8'h02, 8'h40, 8'h40, 8'h40, 8'h40, 8'h01};
  int rel_ch [7] = '{1, 1, 6, 6, 6, 6, 0};

  rr_ch_arbiter_if #(.NUM_CH(8), .DATA_W(32)) bus4 ();
  rr_ch_arbiter_if #(.NUM_CH(8), .DATA_W(32)) bus1 ();

  rr_ch_arbiter #(.NUM_CH(8), .DATA_W(32), .BURST(4)) dut4 (
    .clock     (clk),
    .reset     (rst),
    .ch_enable (en4),
    .beat_cnt  (cnt4),
    .bus       (bus4.slave)
  );

  rr_ch_arbiter #(.NUM_CH(8), .DATA_W(32), .BURST(1)) dut1 (
    .clock     (clk),
    .reset     (rst),
    .ch_enable (en1),
    .beat_cnt  (cnt1),
    .bus       (bus1.slave)
  );

  always #5 clk = ~clk;

  task automatic fill_data;
    for (int i = 0; i < 8; i++) begin
      bus4.in_data[i*32 +: 32] = 32'h100 + 32'(i);
      bus1.in_data[i*32 +: 32] = 32'h100 + 32'(i);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus4.in_valid  = '0;
    bus1.in_valid  = '0;
    bus4.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    en4 = '1;
    en1 = '1;
    fill_data();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en4 = '1;
    en1 = '1;
    fill_data();
    bus4.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    bus4.in_valid = '1;
    bus1.in_valid = '1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus4.in_ready !== 8'h00) begin
      fails++;
      $display("FAIL reset_in_ready4: got %h want 00",
               bus4.in_ready);
    end
    tests++;
    if (bus1.in_ready !== 8'h00) begin
      fails++;
      $display("FAIL reset_in_ready1: got %h want 00",
               bus1.in_ready);
    end
    tests++;
    if (bus4.out_valid !== 1'b0 || bus4.out_data !== 32'h0
        || bus4.out_ch !== 3'd0 || cnt4 !== 16'd0) begin
      fails++;
      $display("FAIL reset_out4: v=%b d=%h ch=%0d cnt=%0d want 0",
               bus4.out_valid, bus4.out_data,
               bus4.out_ch, cnt4);
    end
    tests++;
    if (bus1.out_valid !== 1'b0 || cnt1 !== 16'd0) begin
      fails++;
      $display("FAIL reset_out1: v=%b cnt=%0d want 0",
               bus1.out_valid, cnt1);
    end
    bus4.in_valid = '0;
    bus1.in_valid = '0;
  endtask

  task automatic test_round_robin;
    ch_idx_t    ch;
    ch_idx_t    pc;
    logic [7:0] oh;
    do_reset();
    bus4.in_valid = '1;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      ch = ch_idx_t'((k / 4) % 8);
      oh = 8'b1 << ch;
      tests++;
      if (bus4.in_ready !== oh) begin
        fails++;
        $display("FAIL rr_grant k=%0d: got %h want %h",
                 k, bus4.in_ready, oh);
      end
      if (k > 0) begin
        pc = ch_idx_t'(((k - 1) / 4) % 8);
        tests++;
        if (bus4.out_valid !== 1'b1 || bus4.out_ch !== pc
            || bus4.out_data !== 32'h100 + 32'(pc)) begin
          fails++;
          $display("FAIL rr_out k=%0d: v=%b ch=%0d d=%h want ch=%0d",
                   k, bus4.out_valid, bus4.out_ch,
                   bus4.out_data, pc);
        end
      end
      if (k == 33) begin
        tests++;
        if (cnt4 !== 16'd32) begin
          fails++;
          $display("FAIL rr_beat_cnt: got %0d want 32", cnt4);
        end
      end
      @(posedge clk);
      #1;
    end
    bus4.in_valid = '0;
  endtask

  task automatic test_alternate;
    ch_idx_t    ch;
    ch_idx_t    pc;
    logic [7:0] oh;
    do_reset();
    bus1.in_valid = 8'b0010_1000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      ch = (k % 2 == 1) ? ch_idx_t'(5) : ch_idx_t'(3);
      oh = 8'b1 << ch;
      tests++;
      if (bus1.in_ready !== oh) begin
        fails++;
        $display("FAIL alt_grant k=%0d: got %h want %h",
                 k, bus1.in_ready, oh);
      end
      if (k > 0) begin
        pc = (k % 2 == 0) ? ch_idx_t'(5) : ch_idx_t'(3);
        tests++;
        if (bus1.out_valid !== 1'b1 || bus1.out_ch !== pc) begin
          fails++;
          $display("FAIL alt_out k=%0d: v=%b ch=%0d want ch=%0d",
                   k, bus1.out_valid, bus1.out_ch, pc);
        end
      end
      @(posedge clk);
      #1;
    end
    bus1.in_valid = '0;
  endtask

  task automatic test_stall;
    int   sent;
    int   recv;
    logic acc;
    sent = 0;
    recv = 0;
    do_reset();
    bus4.in_data[2*32 +: 32] = 32'h200;
    bus4.in_valid = 8'b0000_0100;
    for (int c = 0; c < 25; c++) begin
      bus4.out_ready = !(c >= 3 && c < 8);
      @(negedge clk);
      acc = bus4.in_ready[2];
      if (c >= 3 && c < 8) begin
        tests++;
        if (bus4.in_ready !== 8'h00) begin
          fails++;
          $display("FAIL stall_in_ready c=%0d: got %h want 00",
                   c, bus4.in_ready);
        end
        tests++;
        if (bus4.out_valid !== 1'b1 || bus4.out_ch !== 3'd2
            || bus4.out_data !== 32'h200 + 32'(recv)) begin
          fails++;
          $display("FAIL stall_hold c=%0d: v=%b ch=%0d d=%h want d=%h",
                   c, bus4.out_valid, bus4.out_ch,
                   bus4.out_data, 32'h200 + 32'(recv));
        end
      end
      if (bus4.out_valid === 1'b1 && bus4.out_ready) begin
        tests++;
        if (bus4.out_ch !== 3'd2
            || bus4.out_data !== 32'h200 + 32'(recv)) begin
          fails++;
          $display("FAIL stall_recv %0d: ch=%0d d=%h want d=%h",
                   recv, bus4.out_ch, bus4.out_data,
                   32'h200 + 32'(recv));
        end
        recv++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        bus4.in_data[2*32 +: 32] = 32'h200 + 32'(sent);
        if (sent == 10) bus4.in_valid = '0;
      end
    end
    tests++;
    if (sent != 10 || recv != 10) begin
      fails++;
      $display("FAIL stall_count: sent=%0d recv=%0d want 10/10",
               sent, recv);
    end
    bus4.in_valid = '0;
    bus4.out_ready = 1'b1;
  endtask

  task automatic test_release;
    do_reset();
    bus4.in_valid = 8'h42;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      tests++;
      if (bus4.in_ready !== rel_rdy[c]) begin
        fails++;
        $display("FAIL rel_grant c=%0d: got %h want %h",
                 c, bus4.in_ready, rel_rdy[c]);
      end
      if (c > 0) begin
        tests++;
        if (bus4.out_valid !== 1'b1
            || bus4.out_ch !== 3'(rel_ch[c-1])) begin
          fails++;
          $display("FAIL rel_out c=%0d: v=%b ch=%0d want ch=%0d",
                   c, bus4.out_valid, bus4.out_ch, rel_ch[c-1]);
        end
      end
      @(posedge clk);
      #1;
      if (c == 1) bus4.in_valid = 8'h41;
    end
    bus4.in_valid = '0;
  endtask

  task automatic test_mask;
    int         ch;
    logic [7:0] oh;
    do_reset();
    bus4.in_valid = '1;
    en4 = 8'b1111_1011;
    for (int k = 0; k < 37; k++) begin
      if (k == 30) en4 = '1;
      @(negedge clk);
      if (k < 28)      ch = mask_seq[k / 4];
      else if (k < 36) ch = (k - 28) / 4;
      else             ch = 2;
      oh = 8'b1 << ch;
      tests++;
      if (bus4.in_ready !== oh) begin
        fails++;
        $display("FAIL mask_grant k=%0d: got %h want %h",
                 k, bus4.in_ready, oh);
      end
      @(posedge clk);
      #1;
    end
    bus4.in_valid = '0;
    en4 = '1;
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus4.in_valid = 8'h10;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    bus4.out_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if (bus4.out_valid !== 1'b1 || cnt4 !== 16'd4) begin
      fails++;
      $display("FAIL mid_pre: v=%b cnt=%0d want 1/4",
               bus4.out_valid, cnt4);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (bus4.in_ready !== 8'h00) begin
      fails++;
      $display("FAIL mid_rst_ready: got %h want 00",
               bus4.in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus4.in_valid = 8'h82;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (bus4.out_valid !== 1'b0 || cnt4 !== 16'd0) begin
      fails++;
      $display("FAIL mid_post: v=%b cnt=%0d want 0/0",
               bus4.out_valid, cnt4);
    end
    tests++;
    if (bus4.in_ready !== 8'h02) begin
      fails++;
      $display("FAIL mid_first_grant: got %h want 02",
               bus4.in_ready);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if (bus4.out_valid !== 1'b1 || bus4.out_ch !== 3'd1) begin
      fails++;
      $display("FAIL mid_first_out: v=%b ch=%0d want 1/1",
               bus4.out_valid, bus4.out_ch);
    end
    bus4.in_valid = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_alternate();
    test_stall();
    test_release();
    test_mask();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_ch_arbiter.md
Name: rr_ch_arbiter

Overview:
- Round-robin arbiter that merges the eight input channels onto the single output channel in front of the top-level datapath.
- Each input and the output use valid/ready handshakes. The block has a one-entry registered output stage.
- A granted channel may hold the output for up to BURST consecutive beats, after which priority rotates.
- A per-channel enable mask lets software exclude channels from arbitration.

Parameters:
- NUM_CH, 8, number of input channels (power of two, 2..16)
- DATA_W, 32, payload width per beat
- BURST, 4, maximum consecutive beats granted to one channel (1..16)
- CH_W, $clog2(NUM_CH), channel index width (derived, not overridable)

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- ch_enable  in  NUM_CH  per-channel arbitration enable; a masked channel is never granted
- in_valid  in  NUM_CH  per-channel beat valid
- in_data  in  NUM_CH*DATA_W  packed payloads; channel i occupies bits [i*DATA_W +: DATA_W]
- in_ready  out  NUM_CH  per-channel accept, one-hot or zero
- out_valid  out  1  registered output beat valid
- out_data  out  DATA_W  registered output payload
- out_ch  out  CH_W  source channel index of the current output beat
- out_ready  in  1  downstream accept
- beat_cnt  out  16  total beats delivered downstream, saturating at 0xFFFF

Behaviour:
- Reset (synchronous, reset=1 at a clock edge):
  - out_valid=0, out_data=0, out_ch=0, beat_cnt=0.
  - Priority pointer ptr=0, burst counter bc=0, state IDLE.
  - in_ready=0 while reset is high.
  - Reset mid-transfer discards the held output beat; no partial state survives.
- load_en = !out_valid || out_ready. The output register accepts a new beat only when load_en=1.
- Candidate set req = in_valid & ch_enable.
- State IDLE:
  - If load_en && req!=0, grant g = first set bit of req searching upward from ptr, wrapping modulo NUM_CH.
  - in_ready[g]=1 (combinational from state and inputs). The beat loads into the output register. bc=1.
  - Next state is BURST_HOLD when BURST>1, else IDLE with ptr=(g+1)%NUM_CH.
- State BURST_HOLD (owner o = last granted channel):
  - If load_en && req[o]: grant o again and increment bc.
  - When bc reaches BURST: ptr=(o+1)%NUM_CH, go to IDLE.
  - If load_en && !req[o]: release immediately. ptr=(o+1)%NUM_CH, go to IDLE. The arbitration runs in the same cycle as in IDLE, so there is no bubble.
  - If !load_en: hold state; in_ready=0.
- Disabling o via ch_enable while in BURST_HOLD counts as !req[o] and forces release.
- Latency: input beat accepted at edge N appears with out_valid=1 after edge N. Sustained throughput is 1 beat/cycle when out_ready=1.
- out_valid, out_data and out_ch are stable while out_valid && !out_ready. Data is never dropped or duplicated.
- beat_cnt increments on each out_valid && out_ready and saturates at 0xFFFF; it does not wrap.
- At most one in_ready bit is set in any cycle. in_ready is never set for a channel with in_valid=0 or ch_enable=0.
- Fairness: with all channels continuously valid, every enabled channel is granted within (NUM_CH-1)*BURST beats.

Decomposition:
- Package rr_arb_pkg holds:
  - state enum (IDLE, BURST_HOLD)
  - NUM_CH/DATA_W defaults
  - the ch_idx_t typedef
- Sub-module rr_pick: combinational rotating first-one finder. Inputs are req and ptr; outputs are a one-hot grant and an index. It is reused by later schedulers.

Test Plan:
- Reset, then all 8 channels valid with payload = 0x100+ch, BURST=4, out_ready=1:
  - output order is 4 beats from ch0, then 4 from ch1, ..., then ch7, then back to ch0
  - beat_cnt=32 after 32 beats
- Only ch3 and ch5 valid, BURST=1:
  - out_ch alternates 3,5,3,5
  - 1 beat/cycle after the first-cycle latency
- out_ready=0 for 5 cycles while ch2 is active:
  - out_data/out_ch are held stable
  - all in_ready=0
  - no beat lost; count of sent beats = count of received beats
- ch1 drops in_valid after 2 of 4 burst beats while ch6 is valid:
  - grant moves to ch6 on the next cycle with no bubble
  - ptr becomes 2
- ch_enable=8'b1111_1011 with all channels valid:
  - ch2 is never granted and in_ready[2] stays 0
  - re-enabling ch2 mid-run leads to a ch2 grant within 7*BURST beats
- Reset asserted while out_valid=1 and out_ready=0:
  - next cycle out_valid=0 and beat_cnt=0
  - the first grant after reset comes from the lowest valid channel (ptr=0)
